// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and multi-cycle results
// are buffered in a FIFO that drains on idle cycles. A busy scoreboard and a starvation counter support issue stalls.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wb_valid_i,
  input  logic [4:0]                      wb_rd_i,
  input  logic [31:0]                     wb_data_i,
  input  logic                            mc_valid_i,
  output logic                            mc_ready_o,
  input  logic [4:0]                      mc_rd_i,
  input  logic [31:0]                     mc_data_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [4:0]                      issue_rd_i,
  input  logic [4:0]                      chk_rs1_i,
  input  logic [4:0]                      chk_rs2_i,
  input  logic [4:0]                      chk_rd_i,
  output logic                            busy_hit_o,
  output logic                            stall_req_o,
  output logic                            rf_wen_o,
  output logic [4:0]                      rf_waddr_o,
  output logic [31:0]                     rf_wdata_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    rd_mem_q   [FIFO_DEPTH];
  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          stall_q, stall_d;
  logic          wb_win_s, pop_s, push_s, issue_hs_s;
  logic [4:0]    head_rd_s;

  assign head_rd_s    = rd_mem_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign stall_req_o  = stall_q;

  // Handshakes, write-port mux and scoreboard lookups; all come from registered state and current inputs.
  always_comb begin
    wb_win_s      = wb_valid_i && (wb_rd_i != 5'd0);
    pop_s         = !wb_win_s && (count_q != {CW{1'b0}});
    mc_ready_o    = (count_q != CW'(FIFO_DEPTH));
    push_s        = mc_valid_i && mc_ready_o && (mc_rd_i != 5'd0);
    issue_ready_o = !busy_q[issue_rd_i] || (issue_rd_i == 5'd0);
    issue_hs_s    = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);
    busy_hit_o    = ((chk_rs1_i != 5'd0) && busy_q[chk_rs1_i]) ||
                    ((chk_rs2_i != 5'd0) && busy_q[chk_rs2_i]) ||
                    ((chk_rd_i  != 5'd0) && busy_q[chk_rd_i]);
    if (wb_win_s) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = wb_data_i;
    end else if (pop_s) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = head_rd_s;
      rf_wdata_o = data_mem_q[rd_ptr_q];
    end else begin
      rf_wen_o   = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
    end
  end

  // Next-state for FIFO pointers, scoreboard and starvation tracking.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    busy_d   = busy_q;
    if (pop_s) begin
      busy_d[head_rd_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // An issue wins over a same-cycle pop of the same rd; that only happens on a protocol violation.
    if (issue_hs_s) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    if ((count_q == {CW{1'b0}}) || pop_s) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    stall_d = (cnt_d >= 8'(STARVE_LIMIT));
  end

  // State registers; reset drops buffered results and busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_q[i]   <= 5'd0;
        data_mem_q[i] <= 32'd0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      busy_q   <= 32'd0;
      cnt_q    <= 8'd0;
      stall_q  <= 1'b0;
    end else begin
      if (push_s) begin
        rd_mem_q[wr_ptr_q]   <= mc_rd_i;
        data_mem_q[wr_ptr_q] <= mc_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end

endmodule
